led_scan_decoder: RTL and testbench
===================================

Name: led_scan_decoder

Overview:
- Receive-side counterpart of the four-digit multiplexed 7-segment driver. It samples the anode strobes (an3..an0) and the active-low segment bus, and inverts the segment patterns back to hex nibbles.
- It reassembles the 16-bit message originally presented to the driver and flags malformed scans.
- Used as an on-board loopback/monitor and as a self-checking bench component for the display path.

Parameters:
- MIN_ON, 1, minimum consecutive cycles a single anode must be low, with identical segments, for the digit to be accepted.
- CNT_W, 4, width of the strobe-length counter; the counter saturates at all-ones.
- TIMEOUT, 64, cycles with no accepted digit before lock is dropped (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- an3  in  1  anode strobe for digit 3 (MS nibble), active low.
- an2  in  1  anode strobe for digit 2, active low.
- an1  in  1  anode strobe for digit 1, active low.
- an0  in  1  anode strobe for digit 0 (LS nibble), active low.
- led_in  in  7  segment bus, active low; bit6=a … bit0=g; 7'b1111111 = blank.
- ch_out  out  16  last complete frame, {d3,d2,d1,d0}.
- frame_valid  out  1  one-cycle pulse when ch_out updates.
- locked  out  1  high after the first good frame; cleared by any error.
- seg_error  out  1  one-cycle pulse: an accepted strobe carried a non-hex pattern.
- order_error  out  1  one-cycle pulse: digit out of sequence, or more than one anode low.

Behaviour:
- Reset: on a clk edge with reset=1, all outputs go to 0 (ch_out=16'h0000, all pulse outputs and locked low). Input sample registers are set to all-anodes-high and led=7'h7F. FSM enters S_BLANK, expected digit = 3, seen mask = 0.
- Reset mid-frame discards any partial frame; ch_out does not update.
- Input stage: an3..an0 and led_in are registered once (s_an, s_led). All decisions use the registered values.
- Anode classification: all high = blank; exactly one low = strobe on index k; two or more low = illegal.
- S_BLANK state:
  - Single-low sample → go to S_ON, latch k and s_led, cnt=1.
  - Illegal sample → pulse order_error, clear locked, reset the frame tracker (expected=3).
- S_ON state:
  - Same k and same s_led → cnt increments, saturating at 2^CNT_W-1.
  - Any other sample (blank, different k, changed segments, illegal) ends the strobe and triggers evaluation in that same cycle.
  - After evaluation: next state is S_ON with fresh latches if the new sample is a single strobe, else S_BLANK. An illegal new sample also gets the illegal handling above.
- Evaluation:
  - cnt < MIN_ON → strobe ignored silently.
  - Pattern not in the hex table (blank included) → seg_error pulse, locked=0, tracker reset.
  - k==3 → store nibble in d3, expected=2. This applies at any time and restarts the frame with no error.
  - k==expected (2, 1 or 0) → store the nibble, expected decrements.
  - Any other k → order_error pulse, locked=0, tracker reset.
  - Storing d0 completes the frame: on the next edge ch_out={d3,d2,d1,d0}, frame_valid=1 for one cycle, locked=1, expected=3.
- Latency: the first input-sample edge showing the an0 strobe ended is edge E. Then frame_valid and the new ch_out are visible after edge E+2.
- Table: standard hex glyphs, identical to the driver's decoder (e.g. 0=7'b0000001, 8=7'b0000000, F=7'b0111000).
- Simultaneous events: a strobe-end evaluation and a new-strobe start are processed in the same cycle. At most one error pulse is produced per cycle; seg_error takes priority over order_error.

Optional Feature:
- Macro: LED_SCAN_TIMEOUT_EN.
- With the macro defined: an idle counter counts cycles since the last accepted digit. When it reaches TIMEOUT, locked clears and the tracker resets to expected=3, with no error pulse. The counter clears on every accepted digit and on reset.
- Without the macro: no idle counter. locked changes only on reset, errors, or good frames; the TIMEOUT parameter is unused.

Decomposition:
- Package led_scan_pkg holds:
  - segment constants SEG_0..SEG_F and SEG_BLANK (7-bit, active low);
  - state enum {S_BLANK, S_ON};
  - 2-bit digit-index typedef.
- Sub-module seg7_to_hex: purely combinational; 7-bit pattern in, 4-bit nibble plus hit flag out. It is instantiated once.

Test Plan:
- Reset then drive the driver waveform for ch=16'hA5C3, one cycle per anode, 16-cycle frame. Expect: frame_valid pulses once per frame, ch_out=16'hA5C3, locked=1, no error pulses.
- Change the message to 16'h1234 mid-frame. Expect: first full frame still 16'hA5C3 or a clean frame, never a mix of the two; next frame is 16'h1234.
- an3 and an1 low together for one cycle. Expect: order_error pulse, locked=0; next complete frame is accepted.
- Strobe an2 with led_in=7'b1010101 (non-hex). Expect: seg_error, no frame_valid until the next full an3→an0 sequence.
- Sequence an3, an1, an0. Expect: order_error on the an1 strobe; ch_out unchanged.
- With LED_SCAN_TIMEOUT_EN, hold all anodes high for 64 cycles after lock. Expect: locked=0 at cycle 64, no error pulse. Without the macro, locked stays 1.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared constants and types for the 7-segment scan decoder: active-low glyphs
// (bit6=a .. bit0=g), the strobe FSM state type and the digit-index type.
package led_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {S_BLANK, S_ON} state_t;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex glyph table: active-low segment pattern in,
// nibble plus a hit flag out (hit=0 for blank or any non-hex pattern).
module seg7_to_hex
  import led_scan_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       hit_o
);

  always_comb begin
    nib_o = 4'h0;
    hit_o = 1'b1;
    case (seg_i)
      SEG_0:   nib_o = 4'h0;
      SEG_1:   nib_o = 4'h1;
      SEG_2:   nib_o = 4'h2;
      SEG_3:   nib_o = 4'h3;
      SEG_4:   nib_o = 4'h4;
      SEG_5:   nib_o = 4'h5;
      SEG_6:   nib_o = 4'h6;
      SEG_7:   nib_o = 4'h7;
      SEG_8:   nib_o = 4'h8;
      SEG_9:   nib_o = 4'h9;
      SEG_A:   nib_o = 4'hA;
      SEG_B:   nib_o = 4'hB;
      SEG_C:   nib_o = 4'hC;
      SEG_D:   nib_o = 4'hD;
      SEG_E:   nib_o = 4'hE;
      SEG_F:   nib_o = 4'hF;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_scan_decoder.sv
// Recovers the 16-bit message from a multiplexed 7-segment scan and flags
// malformed scans. Define LED_SCAN_TIMEOUT_EN to drop lock after TIMEOUT idle cycles.
module led_scan_decoder
  import led_scan_pkg::*;
#(
  parameter int MIN_ON  = 1,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic [6:0]  led_in,
  output logic [15:0] ch_out,
  output logic        frame_valid,
  output logic        locked,
  output logic        seg_error,
  output logic        order_error
);

  if (MIN_ON > (2 ** CNT_W) - 1) begin : g_min_on_chk
    $error("MIN_ON can never be reached by the saturating strobe counter");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  logic [3:0]       s_an_q;
  logic [6:0]       s_led_q;
  state_t           state_q, state_d;
  digit_idx_t       k_q, k_d, k_in;
  logic [6:0]       led_lat_q, led_lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       exp_q, exp_d, exp_c;
  logic [3:0][3:0]  dig_q, dig_d;
  logic             pend_q, pend_d;
  logic [15:0]      ch_q, ch_d;
  logic             fv_q, fv_d;
  logic             locked_q, locked_d, locked_c;
  logic             serr_q, serr_d;
  logic             oerr_q, oerr_d;
  logic             single, illegal, same, strobe_end, store;
  logic [3:0]       nib;
  logic             hit;
  logic             timeout_hit;

  // Input sample stage: every decision below uses these registered copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_an_q  <= 4'hF;
      s_led_q <= SEG_BLANK;
    end else begin
      s_an_q  <= {an3, an2, an1, an0};
      s_led_q <= led_in;
    end
  end

  always_comb begin
    single  = 1'b0;
    illegal = 1'b0;
    k_in    = 2'd0;
    case (s_an_q)
      4'b0111: begin single = 1'b1; k_in = 2'd3; end
      4'b1011: begin single = 1'b1; k_in = 2'd2; end
      4'b1101: begin single = 1'b1; k_in = 2'd1; end
      4'b1110: begin single = 1'b1; k_in = 2'd0; end
      4'b1111: ;
      default: illegal = 1'b1;
    endcase
  end

  seg7_to_hex u_seg7_to_hex (
    .seg_i (led_lat_q),
    .nib_o (nib),
    .hit_o (hit)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    led_lat_d  = led_lat_q;
    cnt_d      = cnt_q;
    exp_c      = exp_q;
    dig_d      = dig_q;
    locked_c   = locked_q;
    ch_d       = ch_q;
    pend_d     = 1'b0;
    fv_d       = 1'b0;
    serr_d     = 1'b0;
    oerr_d     = 1'b0;
    store      = 1'b0;
    same       = single && (k_in == k_q) && (s_led_q == led_lat_q);
    strobe_end = (state_q == S_ON) && !same;

    if (pend_q) begin
      ch_d     = dig_q;
      fv_d     = 1'b1;
      locked_c = 1'b1;
    end

    if ((state_q == S_ON) && same) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // Strobe evaluation; digit 3 always restarts a frame without complaint.
    if (strobe_end && (int'(cnt_q) >= MIN_ON)) begin
      if (!hit) begin
        serr_d   = 1'b1;
        locked_c = 1'b0;
        exp_c    = 2'd3;
      end else if (k_q == 2'd3) begin
        dig_d[3] = nib;
        exp_c    = 2'd2;
        store    = 1'b1;
      end else if (k_q == exp_q) begin
        dig_d[k_q] = nib;
        store      = 1'b1;
        if (k_q == 2'd0) begin
          pend_d = 1'b1;
          exp_c  = 2'd3;
        end else begin
          exp_c  = exp_q - 1'b1;
        end
      end else begin
        oerr_d   = 1'b1;
        locked_c = 1'b0;
        exp_c    = 2'd3;
      end
    end

    if ((state_q == S_BLANK) || strobe_end) begin
      if (single) begin
        state_d   = S_ON;
        k_d       = k_in;
        led_lat_d = s_led_q;
        cnt_d     = CNT_W'(1);
      end else begin
        state_d   = S_BLANK;
      end
    end

    // Several anodes low at once; a same-cycle seg_error keeps priority.
    if (illegal) begin
      locked_c = 1'b0;
      exp_c    = 2'd3;
      pend_d   = 1'b0;
      oerr_d   = !serr_d;
    end
  end

`ifdef LED_SCAN_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    timeout_hit = !store && (idle_q == IDLE_W'(TIMEOUT - 1));
    if (store) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign locked_d = timeout_hit ? 1'b0 : locked_c;
  assign exp_d    = timeout_hit ? 2'd3 : exp_c;

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_BLANK;
      exp_q    <= 2'd3;
      pend_q   <= 1'b0;
      ch_q     <= 16'h0000;
      fv_q     <= 1'b0;
      locked_q <= 1'b0;
      serr_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      pend_q   <= pend_d;
      ch_q     <= ch_d;
      fv_q     <= fv_d;
      locked_q <= locked_d;
      serr_q   <= serr_d;
      oerr_q   <= oerr_d;
    end
  end

  // Strobe latches and digit store; only meaningful once the FSM has set them.
  always_ff @(posedge clk) begin
    k_q       <= k_d;
    led_lat_q <= led_lat_d;
    cnt_q     <= cnt_d;
    dig_q     <= dig_d;
  end

  assign ch_out      = ch_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign seg_error   = serr_q;
  assign order_error = oerr_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder: drives driver-style scan waveforms and
// checks recovered frames, lock and error pulses against hand-computed values.
module tb_led_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        an3, an2, an1, an0;
  logic [6:0]  led_in;
  logic [15:0] ch_out;
  logic        frame_valid, locked, seg_error, order_error;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_cnt  = 0;
  int serr_cnt = 0;
  int oerr_cnt = 0;
  logic [15:0] fv_log[$];
  logic [15:0] req_msg;

  localparam logic [3:0] AN_IDLE = 4'hF;
  localparam logic [6:0] BLANK   = 7'h7F;

  led_scan_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .an3         (an3),
    .an2         (an2),
    .an1         (an1),
    .an0         (an0),
    .led_in      (led_in),
    .ch_out      (ch_out),
    .frame_valid (frame_valid),
    .locked      (locked),
    .seg_error   (seg_error),
    .order_error (order_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_log.push_back(ch_out);
    end
    if (seg_error)   serr_cnt++;
    if (order_error) oerr_cnt++;
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;  4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;  4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;  4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;  4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;  4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;  default: glyph = 7'b0111000;
    endcase
  endfunction

  function automatic logic [3:0] strobe(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic step(input logic [3:0] an, input logic [6:0] seg);
    {an3, an2, an1, an0} = an;
    led_in = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(AN_IDLE, BLANK);
  endtask

  task automatic scan_raw(input int d, input logic [6:0] seg, input int on_cyc, input int gap);
    repeat (on_cyc) step(strobe(d), seg);
    idle(gap);
  endtask

  task automatic drive_frame(input logic [15:0] msg);
    for (int d = 3; d >= 0; d--) scan_raw(d, glyph(msg[d*4 +: 4]), 1, 3);
  endtask

  task automatic drive_frame_req();
    logic [15:0] m;
    m = req_msg;
    drive_frame(m);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    n_tests++; if (ch_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ch: got %h want 0000", ch_out); end
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_tests++; if ({seg_error, order_error} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {seg_error, order_error}); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_frame();
    int fb, sb, ob;
    fb = fv_cnt; sb = serr_cnt; ob = oerr_cnt;
    drive_frame(16'hA5C3);
    drive_frame(16'hA5C3);
    idle(3);
    n_tests++; if (fv_cnt - fb !== 2) begin n_fail++; $display("FAIL basic_fv_count: got %0d want 2", fv_cnt - fb); end
    n_tests++; if (ch_out !== 16'hA5C3) begin n_fail++; $display("FAIL basic_ch: got %h want A5C3", ch_out); end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_locked: got %b want 1", locked); end
    n_tests++; if ((serr_cnt - sb) + (oerr_cnt - ob) !== 0) begin n_fail++; $display("FAIL basic_errors: got %0d want 0", (serr_cnt - sb) + (oerr_cnt - ob)); end
  endtask

  task automatic test_latency();
    scan_raw(3, glyph(4'hB), 1, 3);
    scan_raw(2, glyph(4'hD), 1, 3);
    scan_raw(1, glyph(4'h9), 1, 3);
    step(strobe(0), glyph(4'h6));
    step(AN_IDLE, BLANK);
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL lat_e0_fv: got %b want 0", frame_valid); end
    step(AN_IDLE, BLANK);
    n_tests++; if (frame_valid !== 1'b0 || ch_out !== 16'hA5C3) begin n_fail++; $display("FAIL lat_e1: got fv=%b ch=%h want fv=0 ch=A5C3", frame_valid, ch_out); end
    step(AN_IDLE, BLANK);
    n_tests++; if (frame_valid !== 1'b1 || ch_out !== 16'hBD96) begin n_fail++; $display("FAIL lat_e2: got fv=%b ch=%h want fv=1 ch=BD96", frame_valid, ch_out); end
    step(AN_IDLE, BLANK);
    n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL lat_e3_fv: got %b want 0", frame_valid); end
  endtask

  task automatic test_msg_change();
    int lb;
    lb = fv_log.size();
    req_msg = 16'hA5C3;
    fork
      drive_frame_req();
      begin
        repeat (6) @(posedge clk);
        req_msg = 16'h1234;
      end
    join
    drive_frame_req();
    idle(3);
    n_tests++; if (fv_log.size() - lb !== 2) begin n_fail++; $display("FAIL chg_count: got %0d want 2", fv_log.size() - lb); end
    else begin
      n_tests++; if (fv_log[lb] !== 16'hA5C3) begin n_fail++; $display("FAIL chg_first: got %h want A5C3", fv_log[lb]); end
      n_tests++; if (fv_log[lb+1] !== 16'h1234) begin n_fail++; $display("FAIL chg_second: got %h want 1234", fv_log[lb+1]); end
    end
  endtask

  task automatic test_back_to_back();
    int fb;
    fb = fv_cnt;
    scan_raw(3, glyph(4'h8), 1, 0);
    scan_raw(2, glyph(4'h4), 1, 0);
    scan_raw(1, glyph(4'h2), 1, 0);
    scan_raw(0, glyph(4'h1), 1, 3);
    idle(2);
    n_tests++; if (fv_cnt - fb !== 1 || ch_out !== 16'h8421) begin n_fail++; $display("FAIL b2b: got n=%0d ch=%h want n=1 ch=8421", fv_cnt - fb, ch_out); end
    fb = fv_cnt;
    for (int d = 3; d >= 0; d--) scan_raw(d, glyph(d[1:0] == 2'd3 ? 4'h7 : d[1:0] == 2'd2 ? 4'hE : d[1:0] == 2'd1 ? 4'h0 : 4'hF), 20, 1);
    idle(3);
    n_tests++; if (fv_cnt - fb !== 1 || ch_out !== 16'h7E0F) begin n_fail++; $display("FAIL long_strobe: got n=%0d ch=%h want n=1 ch=7E0F", fv_cnt - fb, ch_out); end
  endtask

  task automatic test_multi_anode();
    int fb, sb, ob;
    fb = fv_cnt; sb = serr_cnt; ob = oerr_cnt;
    step(4'b0101, glyph(4'h1));
    idle(3);
    n_tests++; if (oerr_cnt - ob !== 1 || serr_cnt - sb !== 0) begin n_fail++; $display("FAIL multi_err: got oerr=%0d serr=%0d want 1 0", oerr_cnt - ob, serr_cnt - sb); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL multi_locked: got %b want 0", locked); end
    drive_frame(16'hA5C3);
    idle(3);
    n_tests++; if (fv_cnt - fb !== 1 || ch_out !== 16'hA5C3 || locked !== 1'b1) begin n_fail++; $display("FAIL multi_recover: got n=%0d ch=%h lk=%b want 1 A5C3 1", fv_cnt - fb, ch_out, locked); end
  endtask

  task automatic test_seg_error();
    int fb, sb, ob;
    fb = fv_cnt; sb = serr_cnt; ob = oerr_cnt;
    scan_raw(2, 7'b1010101, 1, 3);
    n_tests++; if (serr_cnt - sb !== 1 || oerr_cnt - ob !== 0) begin n_fail++; $display("FAIL seg_err: got serr=%0d oerr=%0d want 1 0", serr_cnt - sb, oerr_cnt - ob); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL seg_locked: got %b want 0", locked); end
    scan_raw(1, glyph(4'h3), 1, 3);
    scan_raw(0, glyph(4'h4), 1, 3);
    idle(2);
    n_tests++; if (fv_cnt - fb !== 0 || oerr_cnt - ob !== 2) begin n_fail++; $display("FAIL seg_partial: got n=%0d oerr=%0d want 0 2", fv_cnt - fb, oerr_cnt - ob); end
    drive_frame(16'h1234);
    idle(3);
    n_tests++; if (fv_cnt - fb !== 1 || ch_out !== 16'h1234 || locked !== 1'b1) begin n_fail++; $display("FAIL seg_recover: got n=%0d ch=%h lk=%b want 1 1234 1", fv_cnt - fb, ch_out, locked); end
  endtask

  task automatic test_order();
    int fb, ob;
    fb = fv_cnt; ob = oerr_cnt;
    scan_raw(3, glyph(4'h9), 1, 3);
    scan_raw(1, glyph(4'h9), 1, 3);
    n_tests++; if (oerr_cnt - ob !== 1) begin n_fail++; $display("FAIL order_an1: got %0d want 1", oerr_cnt - ob); end
    scan_raw(0, glyph(4'h9), 1, 3);
    idle(2);
    n_tests++; if (ch_out !== 16'h1234 || fv_cnt - fb !== 0) begin n_fail++; $display("FAIL order_ch: got ch=%h n=%0d want 1234 0", ch_out, fv_cnt - fb); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL order_locked: got %b want 0", locked); end
  endtask

  task automatic test_reset_midframe();
    int fb;
    drive_frame(16'hA5C3);
    idle(3);
    fb = fv_cnt;
    scan_raw(3, glyph(4'h5), 1, 3);
    scan_raw(2, glyph(4'h6), 1, 3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    scan_raw(1, glyph(4'h7), 1, 3);
    scan_raw(0, glyph(4'h8), 1, 3);
    idle(2);
    n_tests++; if (ch_out !== 16'h0000 || fv_cnt - fb !== 0 || locked !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got ch=%h n=%0d lk=%b want 0000 0 0", ch_out, fv_cnt - fb, locked); end
  endtask

  task automatic test_timeout();
    int sb, ob;
    logic exp_lock;
`ifdef LED_SCAN_TIMEOUT_EN
    exp_lock = 1'b0;
`else
    exp_lock = 1'b1;
`endif
    drive_frame(16'hA5C3);
    idle(3);
    sb = serr_cnt; ob = oerr_cnt;
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b want 1", locked); end
    idle(37);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL to_early: got %b want 1", locked); end
    idle(40);
    n_tests++; if (locked !== exp_lock) begin n_fail++; $display("FAIL to_late: got %b want %b", locked, exp_lock); end
    n_tests++; if ((serr_cnt - sb) + (oerr_cnt - ob) !== 0) begin n_fail++; $display("FAIL to_errors: got %0d want 0", (serr_cnt - sb) + (oerr_cnt - ob)); end
  endtask

  initial begin
    reset = 1'b1;
    {an3, an2, an1, an0} = AN_IDLE;
    led_in = BLANK;
    req_msg = 16'h0000;
    test_reset();
    test_basic_frame();
    test_latency();
    test_msg_change();
    test_back_to_back();
    test_multi_anode();
    test_seg_error();
    test_order();
    test_reset_midframe();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
